// File: rtl/ex_mem_stall_if.sv
`default_nettype none
// ============================================================================
//  Module   : ex_mem_stall_if
//  Purpose  : EX -> MEM pipeline-register bundle. It carries the EX-side payload,
//             the registered MEM-side payload, the MADD/MSUB loop-back state and
//             the bubble counter.
//  Revision : 1.0  initial release
// ============================================================================
interface ex_mem_stall_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 2,
    parameter int PERF_W = 16
);
    // EX-stage side
    logic [ADDR_W-1:0]   ex_waddr;
    logic                ex_reg_we;
    logic [DATA_W-1:0]   ex_alu_res;
    logic                ex_hi_we;
    logic                ex_lo_we;
    logic [DATA_W-1:0]   ex_hi;
    logic [DATA_W-1:0]   ex_lo;
    logic [2*DATA_W-1:0] ex_acc_tmp;
    logic [CNT_W-1:0]    ex_cnt;

    // MEM-stage side and loop-back to EX
    logic [ADDR_W-1:0]   mem_waddr;
    logic                mem_reg_we;
    logic [DATA_W-1:0]   mem_alu_res;
    logic                mem_hi_we;
    logic                mem_lo_we;
    logic [DATA_W-1:0]   mem_hi;
    logic [DATA_W-1:0]   mem_lo;
    logic                mem_valid;
    logic [2*DATA_W-1:0] acc_tmp_o;
    logic [CNT_W-1:0]    cnt_o;
    logic [PERF_W-1:0]   bubble_cnt;

    // Execute stage: drives the payload and consumes the registered results
    modport master (
        output ex_waddr, ex_reg_we, ex_alu_res, ex_hi_we, ex_lo_we,
               ex_hi, ex_lo, ex_acc_tmp, ex_cnt,
        input  mem_waddr, mem_reg_we, mem_alu_res, mem_hi_we, mem_lo_we,
               mem_hi, mem_lo, mem_valid, acc_tmp_o, cnt_o, bubble_cnt
    );

    // Pipeline register itself
    modport slave (
        input  ex_waddr, ex_reg_we, ex_alu_res, ex_hi_we, ex_lo_we,
               ex_hi, ex_lo, ex_acc_tmp, ex_cnt,
        output mem_waddr, mem_reg_we, mem_alu_res, mem_hi_we, mem_lo_we,
               mem_hi, mem_lo, mem_valid, acc_tmp_o, cnt_o, bubble_cnt
    );
endinterface
`default_nettype wire

// File: rtl/ex_mem_stall.sv
`default_nettype none
// ============================================================================
//  Module   : ex_mem_stall
//  Purpose  : EX/MEM pipeline register with stall hold, bubble insertion,
//             flush, a valid flag, MADD/MSUB loop-back state and a saturating
//             bubble counter. All outputs are registered.
//  Revision : 1.0  initial release
// ============================================================================
module ex_mem_stall #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 2,
    parameter int PERF_W = 16
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        stall_ex_i,
    input  wire logic        stall_mem_i,
    input  wire logic        flush_i,
    ex_mem_stall_if.slave    bus
);

    localparam logic [PERF_W-1:0] c_PERF_ONE = {{(PERF_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0]   waddr_q,   waddr_d;
    logic                reg_we_q,  reg_we_d;
    logic [DATA_W-1:0]   alu_res_q, alu_res_d;
    logic                hi_we_q,   hi_we_d;
    logic                lo_we_q,   lo_we_d;
    logic [DATA_W-1:0]   hi_q,      hi_d;
    logic [DATA_W-1:0]   lo_q,      lo_d;
    logic                valid_q,   valid_d;
    logic [2*DATA_W-1:0] acc_q,     acc_d;
    logic [CNT_W-1:0]    cnt_q,     cnt_d;
    logic [PERF_W-1:0]   bubble_q,  bubble_d;

    // Next-state selection. Priority is flush, then MEM stall (hold), then EX stall (bubble), then capture.
    always_comb begin
        waddr_d   = waddr_q;
        reg_we_d  = reg_we_q;
        alu_res_d = alu_res_q;
        hi_we_d   = hi_we_q;
        lo_we_d   = lo_we_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        valid_d   = valid_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        bubble_d  = bubble_q;

        if (flush_i) begin
            // Flush beats a MEM stall so that a held write cannot leak through.
            waddr_d   = '0;
            reg_we_d  = 1'b0;
            alu_res_d = '0;
            hi_we_d   = 1'b0;
            lo_we_d   = 1'b0;
            hi_d      = '0;
            lo_d      = '0;
            valid_d   = 1'b0;
            acc_d     = '0;
            cnt_d     = '0;
        end else if (stall_mem_i) begin
            // Hold everything, including the loop-back state and the counter.
        end else if (stall_ex_i) begin
            waddr_d   = '0;
            reg_we_d  = 1'b0;
            alu_res_d = '0;
            hi_we_d   = 1'b0;
            lo_we_d   = 1'b0;
            hi_d      = '0;
            lo_d      = '0;
            valid_d   = 1'b0;
            // Partial MADD/MSUB product survives only across consecutive EX stalls.
            acc_d     = bus.ex_acc_tmp;
            cnt_d     = bus.ex_cnt;
            if (!(&bubble_q)) begin
                bubble_d = bubble_q + c_PERF_ONE;
            end
        end else begin
            waddr_d   = bus.ex_waddr;
            reg_we_d  = bus.ex_reg_we;
            alu_res_d = bus.ex_alu_res;
            hi_we_d   = bus.ex_hi_we;
            lo_we_d   = bus.ex_lo_we;
            hi_d      = bus.ex_hi;
            lo_d      = bus.ex_lo;
            valid_d   = 1'b1;
            acc_d     = '0;
            cnt_d     = '0;
        end
    end

    // State register with synchronous reset that clears every output.
    always_ff @(posedge clk) begin
        if (rst) begin
            waddr_q   <= '0;
            reg_we_q  <= 1'b0;
            alu_res_q <= '0;
            hi_we_q   <= 1'b0;
            lo_we_q   <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            valid_q   <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            bubble_q  <= '0;
        end else begin
            waddr_q   <= waddr_d;
            reg_we_q  <= reg_we_d;
            alu_res_q <= alu_res_d;
            hi_we_q   <= hi_we_d;
            lo_we_q   <= lo_we_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            valid_q   <= valid_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            bubble_q  <= bubble_d;
        end
    end

    assign bus.mem_waddr   = waddr_q;
    assign bus.mem_reg_we  = reg_we_q;
    assign bus.mem_alu_res = alu_res_q;
    assign bus.mem_hi_we   = hi_we_q;
    assign bus.mem_lo_we   = lo_we_q;
    assign bus.mem_hi      = hi_q;
    assign bus.mem_lo      = lo_q;
    assign bus.mem_valid   = valid_q;
    assign bus.acc_tmp_o   = acc_q;
    assign bus.cnt_o       = cnt_q;
    assign bus.bubble_cnt  = bubble_q;

endmodule
`default_nettype wire
